// File: rtl/iob_sched.sv
// iob_sched: orders FSB I/O accesses onto the single IOB master.
//   Posted shadow writes (IOCS & IOPWCS) go into a DEPTH-entry FIFO and get RDY
//   after 2 edges. Blocking ops (IOCS alone, or IACS) run in program order behind them.
// Ports: CLK/RES; CPU side BACT, IOCS, IOPWCS, IACS, nWE, nUDS, nLDS, A, DIN -> RDY, DOUT;
//   IOB side IOREQ/IOACK/IODONE handshake, IODIN in, IOA/IOD/IOWE/IOUDS/IOLDS out.
module iob_sched #(
  parameter int DEPTH = 2,
  parameter int AW    = 23
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          BACT,
  input  logic          IOCS,
  input  logic          IOPWCS,
  input  logic          IACS,
  input  logic          nWE,
  input  logic          nUDS,
  input  logic          nLDS,
  input  logic [AW-1:0] A,
  input  logic [15:0]   DIN,
  output logic          RDY,
  output logic [15:0]   DOUT,
  output logic          IOREQ,
  input  logic          IOACK,
  input  logic          IODONE,
  input  logic [15:0]   IODIN,
  output logic [AW-1:0] IOA,
  output logic [15:0]   IOD,
  output logic          IOWE,
  output logic          IOUDS,
  output logic          IOLDS
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {F_IDLE, F_PUSH, F_BLKQ, F_BLKW, F_DONE} f_state_t;
  typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} b_state_t;

  f_state_t        f_state_q, f_state_d;
  b_state_t        b_state_q, b_state_d;
  logic            iack_q, iack_d;
  logic [15:0]     dout_q, dout_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]   ioa_q, ioa_d;
  logic [15:0]     iod_q, iod_d;
  logic            iowe_q, iowe_d;
  logic            iouds_q, iouds_d;
  logic            iolds_q, iolds_d;
  logic            src_fifo_q, src_fifo_d;

  // Posted-write storage; every entry is a write, so only address, data and strobes are kept.
  logic [AW-1:0]   fa_q [DEPTH];
  logic [15:0]     fd_q [DEPTH];
  logic [1:0]      fs_q [DEPTH];

  logic is_post, is_blk, push, pop, blk_go, blk_done;

  assign is_post  = IOCS & IOPWCS;
  assign is_blk   = (IOCS | IACS) & ~is_post;
  // Registered count only: a pop on the same edge does not make room for this push.
  assign push     = (f_state_q == F_PUSH) & BACT & (count_q < CW'(DEPTH));
  assign pop      = (b_state_q == B_WAIT) & IODONE & src_fifo_q;
  assign blk_done = (b_state_q == B_WAIT) & IODONE & ~src_fifo_q;
  // A blocking op is handed over only once every earlier posted write has retired.
  assign blk_go   = (f_state_q == F_BLKQ) & BACT & (count_q == '0) & (b_state_q == B_IDLE);

  // Front FSM: CPU-side cycle sequencing.
  always_comb begin
    f_state_d = f_state_q;
    iack_d    = iack_q;
    dout_d    = dout_q;
    unique case (f_state_q)
      F_IDLE: begin
        if (BACT && is_post) begin
          f_state_d = F_PUSH;
        end else if (BACT && is_blk) begin
          f_state_d = F_BLKQ;
          iack_d    = IACS;
        end
      end
      F_PUSH: begin
        if (!BACT)     f_state_d = F_IDLE;
        else if (push) f_state_d = F_DONE;
      end
      F_BLKQ: begin
        if (!BACT)       f_state_d = F_IDLE;
        else if (blk_go) f_state_d = F_BLKW;
      end
      F_BLKW: begin
        // An aborted cycle leaves the back FSM to finish; its completion is then ignored.
        if (!BACT) begin
          f_state_d = F_IDLE;
        end else if (blk_done) begin
          if (!iowe_q) dout_d = IODIN;
          f_state_d = F_DONE;
        end
      end
      F_DONE: begin
        if (!BACT) f_state_d = F_IDLE;
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  // Back FSM: owns the IOB handshake and the registered IOB outputs.
  always_comb begin
    b_state_d  = b_state_q;
    ioa_d      = ioa_q;
    iod_d      = iod_q;
    iowe_d     = iowe_q;
    iouds_d    = iouds_q;
    iolds_d    = iolds_q;
    src_fifo_d = src_fifo_q;
    unique case (b_state_q)
      B_IDLE: begin
        if (count_q != '0) begin
          ioa_d      = fa_q[head_q];
          iod_d      = fd_q[head_q];
          iowe_d     = 1'b1;
          {iouds_d, iolds_d} = fs_q[head_q];
          src_fifo_d = 1'b1;
          b_state_d  = B_REQ;
        end else if (blk_go) begin
          ioa_d      = A;
          iod_d      = DIN;
          iowe_d     = ~nWE & ~iack_q;
          iouds_d    = ~nUDS;
          iolds_d    = ~nLDS;
          src_fifo_d = 1'b0;
          b_state_d  = B_REQ;
        end
      end
      B_REQ:   if (IOACK)  b_state_d = B_WAIT;
      B_WAIT:  if (IODONE) b_state_d = B_IDLE;
      default: b_state_d = B_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      f_state_q  <= F_IDLE;
      b_state_q  <= B_IDLE;
      iack_q     <= 1'b0;
      dout_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      ioa_q      <= '0;
      iod_q      <= '0;
      iowe_q     <= 1'b0;
      iouds_q    <= 1'b0;
      iolds_q    <= 1'b0;
      src_fifo_q <= 1'b0;
    end else begin
      f_state_q  <= f_state_d;
      b_state_q  <= b_state_d;
      iack_q     <= iack_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ioa_q      <= ioa_d;
      iod_q      <= iod_d;
      iowe_q     <= iowe_d;
      iouds_q    <= iouds_d;
      iolds_q    <= iolds_d;
      src_fifo_q <= src_fifo_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fa_q[tail_q] <= A;
      fd_q[tail_q] <= DIN;
      fs_q[tail_q] <= {~nUDS, ~nLDS};
    end
  end

  assign RDY   = (f_state_q == F_DONE);
  assign IOREQ = (b_state_q == B_REQ);
  assign DOUT  = dout_q;
  assign IOA   = ioa_q;
  assign IOD   = iod_q;
  assign IOWE  = iowe_q;
  assign IOUDS = iouds_q;
  assign IOLDS = iolds_q;

endmodule

// File: tb/tb_iob_sched.sv
module tb_iob_sched;
  logic        CLK = 1'b0;
  logic        RES, BACT, IOCS, IOPWCS, IACS, nWE, nUDS, nLDS;
  logic [22:0] A;
  logic [15:0] DIN;
  logic        RDY;
  logic [15:0] DOUT;
  logic        IOREQ, IOACK, IODONE;
  logic [15:0] IODIN;
  logic [22:0] IOA;
  logic [15:0] IOD;
  logic        IOWE, IOUDS, IOLDS;

  iob_sched #(.DEPTH(2), .AW(23)) dut (
    .CLK(CLK), .RES(RES), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS), .IACS(IACS),
    .nWE(nWE), .nUDS(nUDS), .nLDS(nLDS), .A(A), .DIN(DIN), .RDY(RDY), .DOUT(DOUT),
    .IOREQ(IOREQ), .IOACK(IOACK), .IODONE(IODONE), .IODIN(IODIN), .IOA(IOA), .IOD(IOD),
    .IOWE(IOWE), .IOUDS(IOUDS), .IOLDS(IOLDS)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
    logic        we;
    logic        u;
    logic        l;
  } txn_t;

  txn_t        obs[$];
  int          done_cycs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        slave_en = 1'b0, hold_done = 1'b0, rd_fixed_en = 1'b0;
  logic [15:0] rd_fixed = 16'h0;
  int          ack_dly = 0, done_dly = 0;

  function automatic logic [15:0] rd_fn(input logic [22:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [22:0] baddr(input logic [23:0] byte_addr);
    return byte_addr[23:1];
  endfunction

  // IOB master model: acks after ack_dly, completes after done_dly (or while hold_done),
  // and checks that the IOB outputs stay put for the whole transaction.
  initial begin
    txn_t cap;
    logic stable;
    IOACK = 1'b0; IODONE = 1'b0; IODIN = 16'h0;
    forever begin
      @(negedge CLK);
      if (slave_en && IOREQ && !RES) begin
        cap = {IOA, IOD, IOWE, IOUDS, IOLDS};
        stable = 1'b1;
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge CLK);
          if ({IOA, IOD, IOWE, IOUDS, IOLDS} !== cap || !IOREQ) stable = 1'b0;
        end
        IOACK = 1'b1;
        @(negedge CLK);
        IOACK = 1'b0;
        if ({IOA, IOD, IOWE, IOUDS, IOLDS} !== cap || IOREQ) stable = 1'b0;
        for (int i = 0; i < done_dly; i++) begin
          @(negedge CLK);
          if ({IOA, IOD, IOWE, IOUDS, IOLDS} !== cap || IOREQ) stable = 1'b0;
        end
        while (hold_done) begin
          @(negedge CLK);
          if ({IOA, IOD, IOWE, IOUDS, IOLDS} !== cap || IOREQ) stable = 1'b0;
        end
        IODIN = rd_fixed_en ? rd_fixed : rd_fn(cap.a);
        IODONE = 1'b1;
        done_cycs.push_back(cyc);
        @(negedge CLK);
        IODONE = 1'b0;
        obs.push_back(cap);
        n_cmp++;
        if (!stable) begin
          n_bad++;
          $display("FAIL iob_hold: outputs/IOREQ changed during txn at %h, got unstable want stable", cap.a);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // One CPU bus cycle, started and ended at a negedge.
  task automatic cpu_cycle(input logic [2:0] sel, input logic nwe, nuds, nlds,
                           input logic [22:0] a, input logic [15:0] d,
                           input int maxw, input int hold,
                           output int lat, output logic [15:0] dout,
                           output logic held_ok, output logic rdy_after, output logic req_seen);
    {IOCS, IOPWCS, IACS} = sel;
    nWE = nwe; nUDS = nuds; nLDS = nlds; A = a; DIN = d; BACT = 1'b1;
    lat = -1; held_ok = 1'b1; req_seen = 1'b0;
    for (int k = 1; k <= maxw; k++) begin
      @(negedge CLK);
      if (IOREQ) req_seen = 1'b1;
      if (RDY) begin
        lat = k;
        break;
      end
    end
    dout = DOUT;
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      if (!RDY) held_ok = 1'b0;
    end
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; IACS = 1'b0;
    @(negedge CLK);
    rdy_after = RDY;
  endtask

  task automatic drain(input int n);
    int w = 0;
    while (obs.size() < n && w < 400) begin
      @(negedge CLK);
      w++;
    end
    if (obs.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d IOB txns want %0d", obs.size(), n);
    end
  endtask

  task automatic test_reset_state();
    repeat (2) @(negedge CLK);
    n_cmp++; if ({RDY, IOREQ, IOWE, IOUDS, IOLDS} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 00000", {RDY, IOREQ, IOWE, IOUDS, IOLDS}); end
    n_cmp++; if (IOA !== 23'h0) begin n_bad++; $display("FAIL reset_ioa: got %h want 0", IOA); end
    n_cmp++; if (IOD !== 16'h0) begin n_bad++; $display("FAIL reset_iod: got %h want 0", IOD); end
    n_cmp++; if (DOUT !== 16'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", DOUT); end
    RES = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] dv; logic h, ra, rs;
    logic seen;
    slave_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_cycle(3'b110, 1'b0, 1'b0, 1'b0, 23'($urandom), 16'($urandom), 20, 0, lat, dv, h, ra, rs);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rstmid_post_lat: got %0d want 2", lat); end
    end
    n_cmp++; if (IOREQ !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_before: got %b want 1", IOREQ); end
    #2 RES = 1'b1;
    #1;
    n_cmp++; if (IOREQ !== 1'b0) begin n_bad++; $display("FAIL rstmid_req_async: got %b want 0", IOREQ); end
    n_cmp++; if (dut.count_q !== 2'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", dut.count_q); end
    n_cmp++; if (RDY !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdy: got %b want 0", RDY); end
    @(negedge CLK);
    RES = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (IOREQ || RDY) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: got activity %b want 0", seen); end
    slave_en = 1'b1;
  endtask

  task automatic test_single_post();
    int lat; logic [15:0] dv; logic h, ra, rs;
    txn_t e;
    logic [22:0] a;
    obs.delete(); ack_dly = 1; done_dly = 4; hold_done = 1'b0;
    a = baddr(24'h3FA100);
    cpu_cycle(3'b110, 1'b0, 1'b0, 1'b0, a, 16'h1234, 20, 0, lat, dv, h, ra, rs);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL post_lat: got %0d want 2", lat); end
    n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL post_rdy_drop: got %b want 0", ra); end
    drain(1);
    e = {a, 16'h1234, 1'b1, 1'b1, 1'b1};
    n_cmp++; if (obs[0] !== e) begin n_bad++; $display("FAIL post_txn: got %h want %h", obs[0], e); end
    repeat (2) @(negedge CLK);
    n_cmp++; if (dut.count_q !== 2'd0) begin n_bad++; $display("FAIL post_count: got %0d want 0", dut.count_q); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] dv; logic h, ra, rs;
    logic [22:0] a[3];
    logic [15:0] d[3];
    logic stalled;
    int c_rdy;
    obs.delete(); done_cycs.delete();
    ack_dly = 0; done_dly = 0; hold_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i] = 23'($urandom); d[i] = 16'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      cpu_cycle(3'b110, 1'b0, 1'b0, 1'b1, a[i], d[i], 20, 0, lat, dv, h, ra, rs);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_lat%0d: got %0d want 2", i, lat); end
    end
    IOCS = 1'b1; IOPWCS = 1'b1; IACS = 1'b0; nWE = 1'b0; nUDS = 1'b0; nLDS = 1'b1;
    A = a[2]; DIN = d[2]; BACT = 1'b1;
    stalled = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (RDY) stalled = 1'b1;
    end
    n_cmp++; if (stalled !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got RDY %b want 0", stalled); end
    hold_done = 1'b0;
    c_rdy = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (RDY) begin
        c_rdy = cyc;
        break;
      end
    end
    n_cmp++;
    if (done_cycs.size() == 0 || c_rdy < 0 || c_rdy - done_cycs[0] != 2) begin
      n_bad++;
      $display("FAIL b2b_third_rdy: got rdy at edge %0d want first IODONE edge+1 (done %0d)", c_rdy, done_cycs.size() > 0 ? done_cycs[0] : -1);
    end
    BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0;
    @(negedge CLK);
    drain(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs[i].a !== a[i] || obs[i].d !== d[i] || obs[i].we !== 1'b1) begin
        n_bad++; $display("FAIL b2b_order%0d: got %h/%h want %h/%h", i, obs[i].a, obs[i].d, a[i], d[i]);
      end
    end
  endtask

  task automatic test_post_then_read();
    int lat; logic [15:0] dv; logic h, ra, rs;
    logic [22:0] ap, ar;
    obs.delete(); ack_dly = 2; done_dly = 6; rd_fixed_en = 1'b1; rd_fixed = 16'h00A5;
    ap = 23'($urandom); ar = baddr(24'hEFE1FE);
    cpu_cycle(3'b110, 1'b0, 1'b0, 1'b0, ap, 16'($urandom), 20, 0, lat, dv, h, ra, rs);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ptr_post_lat: got %0d want 2", lat); end
    cpu_cycle(3'b100, 1'b1, 1'b0, 1'b0, ar, 16'hFFFF, 100, 0, lat, dv, h, ra, rs);
    n_cmp++; if (lat < 0 || dv !== 16'h00A5) begin n_bad++; $display("FAIL ptr_dout: got %h (lat %0d) want 00a5", dv, lat); end
    drain(2);
    n_cmp++; if (obs[0].a !== ap || obs[0].we !== 1'b1) begin n_bad++; $display("FAIL ptr_first: got %h we %b want %h we 1", obs[0].a, obs[0].we, ap); end
    n_cmp++; if (obs[1].a !== ar || obs[1].we !== 1'b0 || obs[1].u !== 1'b1 || obs[1].l !== 1'b1) begin
      n_bad++; $display("FAIL ptr_read: got %h we %b want %h we 0", obs[1].a, obs[1].we, ar);
    end
    rd_fixed_en = 1'b0;
  endtask

  task automatic test_iack();
    int lat; logic [15:0] dv; logic h, ra, rs;
    logic [22:0] a;
    obs.delete(); ack_dly = 1; done_dly = 2; rd_fixed_en = 1'b1; rd_fixed = 16'h0019;
    a = baddr(24'hFFFFF6);
    cpu_cycle(3'b001, 1'b0, 1'b1, 1'b0, a, 16'h5555, 60, 3, lat, dv, h, ra, rs);
    n_cmp++; if (lat < 0 || dv !== 16'h0019) begin n_bad++; $display("FAIL iack_dout: got %h (lat %0d) want 0019", dv, lat); end
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL iack_rdy_hold: got %b want 1", h); end
    n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL iack_rdy_drop: got %b want 0", ra); end
    drain(1);
    n_cmp++; if (obs[0].we !== 1'b0 || obs[0].a !== a) begin n_bad++; $display("FAIL iack_txn: got %h we %b want %h we 0", obs[0].a, obs[0].we, a); end
    rd_fixed_en = 1'b0;
  endtask

  task automatic test_none();
    int lat; logic [15:0] dv; logic h, ra, rs;
    obs.delete();
    cpu_cycle(3'b000, 1'b1, 1'b0, 1'b0, 23'($urandom), 16'h0, 8, 0, lat, dv, h, ra, rs);
    n_cmp++; if (lat !== -1) begin n_bad++; $display("FAIL none_rdy: got lat %0d want none", lat); end
    n_cmp++; if (rs !== 1'b0 || obs.size() != 0) begin n_bad++; $display("FAIL none_req: got req %b txns %0d want 0 0", rs, obs.size()); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] dv; logic h, ra, rs;
    txn_t exp_q[$];
    txn_t e;
    logic [15:0] dout_m;
    int cls;
    logic [22:0] a;
    logic [15:0] d;
    logic nu, nl;
    obs.delete(); rd_fixed_en = 1'b0;
    dout_m = DOUT;
    for (int it = 0; it < 40; it++) begin
      ack_dly = int'($urandom_range(0, 3)); done_dly = int'($urandom_range(0, 5));
      cls = int'($urandom_range(0, 4));
      a = 23'($urandom); d = 16'($urandom);
      nu = 1'($urandom); nl = 1'($urandom);
      case (cls)
        0: begin
          cpu_cycle(3'b110, 1'b0, nu, nl, a, d, 200, 0, lat, dv, h, ra, rs);
          exp_q.push_back({a, d, 1'b1, ~nu, ~nl});
        end
        1: begin
          cpu_cycle(3'b100, 1'b1, nu, nl, a, d, 200, 0, lat, dv, h, ra, rs);
          exp_q.push_back({a, d, 1'b0, ~nu, ~nl});
          dout_m = rd_fn(a);
        end
        2: begin
          cpu_cycle(3'b100, 1'b0, nu, nl, a, d, 200, 0, lat, dv, h, ra, rs);
          exp_q.push_back({a, d, 1'b1, ~nu, ~nl});
        end
        3: begin
          cpu_cycle(3'b001, 1'($urandom), nu, nl, a, d, 200, 0, lat, dv, h, ra, rs);
          exp_q.push_back({a, d, 1'b0, ~nu, ~nl});
          dout_m = rd_fn(a);
        end
        default: cpu_cycle(3'b000, 1'b0, nu, nl, a, d, 6, 0, lat, dv, h, ra, rs);
      endcase
      n_cmp++;
      if (cls == 4 ? (lat != -1) : (lat < 0 || dv !== dout_m)) begin
        n_bad++; $display("FAIL rnd_cycle%0d cls %0d: got lat %0d dout %h want dout %h", it, cls, lat, dv, dout_m);
      end
    end
    drain(exp_q.size());
    n_cmp++; if (obs.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      n_cmp++;
      if (obs[i].a !== e.a || obs[i].we !== e.we || obs[i].u !== e.u || obs[i].l !== e.l ||
          (e.we && obs[i].d !== e.d)) begin
        n_bad++; $display("FAIL rnd_txn%0d: got %h want %h", i, obs[i], e);
      end
    end
  endtask

  initial begin
    RES = 1'b1; BACT = 1'b0; IOCS = 1'b0; IOPWCS = 1'b0; IACS = 1'b0;
    nWE = 1'b1; nUDS = 1'b1; nLDS = 1'b1; A = '0; DIN = '0;
    test_reset_state();
    test_reset_mid();
    test_single_post();
    test_back_to_back();
    test_post_then_read();
    test_iack();
    test_none();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
